// File: rtl/mips_pkg.sv
// Shared definitions for the 1:2 pipelined demux: default word width and the
// per-output slot state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register stage: a load appears on o_valid the next cycle.
// Accepts a new word while empty or while the held word drains in the same cycle.
module demux_slot
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_space
);

    slot_state_t      r_state;
    slot_state_t      w_next_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (i_load) w_next_state = FULL;
            FULL:  if (i_ready && !i_load) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    always_comb begin
        o_valid = (r_state == FULL);
        o_space = (r_state == EMPTY) || i_ready;
    end

    // Data only moves on a load, so it holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/demux1_2_pipe.sv
// 1:2 demux with one register slot per output (latency 1); in_ready follows the
// selected slot's space. Optional delivered-word counters under DEMUX_COUNT_EN.
module demux1_2_pipe
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    logic w_space0;
    logic w_space1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    assign in_ready = in_sel ? w_space1 : w_space0;
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && !in_sel;
    assign w_load1  = w_accept &&  in_sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data),
        .o_space (w_space0)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data),
        .o_space (w_space1)
    );

`ifdef DEMUX_COUNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Counts completed downstream transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) r_cnt0 <= r_cnt0 + 16'd1;
            if (out1_valid && out1_ready) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux1_2_pipe.sv
// Directed bench for demux1_2_pipe: inputs change on the falling edge, outputs
// are compared away from the rising edge.
module tb_demux1_2_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int n_chk = 0;
    int n_err = 0;

    demux1_2_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_v0", {31'd0, out0_valid}, 32'd0);
        chk("rst_v1", {31'd0, out1_valid}, 32'd0);
        chk("rst_d0", out0_data, 32'd0);
        chk("rst_d1", out1_data, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single route to port 0
        @(negedge clk);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF; out0_ready = 1'b1;
        #1 chk("sr_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_sel = 1'b1; in_data = 32'h12345678;
        chk("sr_v0", {31'd0, out0_valid}, 32'd1);
        chk("sr_d0", out0_data, 32'hDEADBEEF);
        chk("sr_v1", {31'd0, out1_valid}, 32'd0);
        @(negedge clk);
        chk("sr_drain_v0", {31'd0, out0_valid}, 32'd0);
        chk("idle_v1", {31'd0, out1_valid}, 32'd0);

        // Backpressure on port 1
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h11111111;
        #1 chk("bp_rdy_first", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_data = 32'h22222222;
        #1 chk("bp_rdy_sel1", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_v1", {31'd0, out1_valid}, 32'd1);
        chk("bp_d1", out1_data, 32'h11111111);
        in_valid = 1'b0; in_sel = 1'b0;
        #1 chk("bp_rdy_sel0", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1 chk("bp_rdy_sel1b", {31'd0, in_ready}, 32'd0);
        out1_ready = 1'b1;
        #1 chk("bp_rdy_pass", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_drain_v1", {31'd0, out1_valid}, 32'd0);
        chk("bp_v0_idle", {31'd0, out0_valid}, 32'd0);

        // Streaming, alternating select, both outputs ready
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = i[0]; in_data = 32'(i);
            #1 chk($sformatf("st_rdy%0d", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            if (i[0]) begin
                chk($sformatf("st_v1_%0d", i), {31'd0, out1_valid}, 32'd1);
                chk($sformatf("st_d1_%0d", i), out1_data, 32'(i));
                chk($sformatf("st_v0off_%0d", i), {31'd0, out0_valid}, 32'd0);
            end else begin
                chk($sformatf("st_v0_%0d", i), {31'd0, out0_valid}, 32'd1);
                chk($sformatf("st_d0_%0d", i), out0_data, 32'(i));
                chk($sformatf("st_v1off_%0d", i), {31'd0, out1_valid}, (i == 0) ? 32'd0 : 32'd0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("st_end_v0", {31'd0, out0_valid}, 32'd0);
        chk("st_end_v1", {31'd0, out1_valid}, 32'd0);

        // Simultaneous drain and load on port 0
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
        @(negedge clk);
        chk("sd_vA", {31'd0, out0_valid}, 32'd1);
        chk("sd_dA", out0_data, 32'hA);
        out0_ready = 1'b1; in_data = 32'hB;
        #1 chk("sd_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sd_vB", {31'd0, out0_valid}, 32'd1);
        chk("sd_dB", out0_data, 32'hB);
        @(negedge clk);
        chk("sd_drain", {31'd0, out0_valid}, 32'd0);

        // Reset while both slots hold words
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
        @(negedge clk);
        in_sel = 1'b1; in_data = 32'h66;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_d0", out0_data, 32'h55);
        chk("mr_d1", out1_data, 32'h66);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_v0", {31'd0, out0_valid}, 32'd0);
        chk("mr_v1", {31'd0, out1_valid}, 32'd0);
        chk("mr_dz0", out0_data, 32'd0);
        chk("mr_dz1", out1_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_sel = 1'b1;
        #1 chk("mr_rdy1", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b0;
        #1 chk("mr_rdy0", {31'd0, in_ready}, 32'd1);

`ifdef DEMUX_COUNT_EN
        // Counter wrap on port 0
        chk("cnt0_rst", {16'd0, cnt0}, 32'd0);
        chk("cnt1_rst", {16'd0, cnt1}, 32'd0);
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            in_data = in_data + 32'd1;
        end
        chk("cnt0_ffff", {16'd0, cnt0}, 32'h0000FFFF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("cnt0_wrap", {16'd0, cnt0}, 32'd0);
        chk("cnt1_hold", {16'd0, cnt1}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
